fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Fetch-stage sequencer: owns the fetch PC and drives the instruction-bus request.
//  Holds each request stable until the bus completes it.
//  Delivers {pc, inst} to decode through a registered output slot plus a one-entry skid.
//  Applies redirects (jump/branch/trap), decode back-pressure, and flush of in-flight fetches.
// PARAMETERS
//  RESET_PC  64'h8000_0000  PC fetched first after reset release
//  INST_W    32             instruction width
// PORTS
//  clk             in   1       clock, all state updates on posedge
//  reset           in   1       synchronous, active-low: reset==0 at posedge resets block
//  ireq_valid      out  1       instruction-bus request
//  ireq_addr       out  64      request address; stable while ireq_valid && !iresp_ok
//  iresp_ok        in   1       bus completes current request this cycle; data valid
//  iresp_data      in   INST_W  instruction returned with iresp_ok
//  redirect_valid  in   1       one-cycle pulse: restart fetch at redirect_pc
//  redirect_pc     in   64      redirect target, 4-byte aligned
//  stall           in   1       decode cannot accept (load-use / downstream handshake)
//  out_valid       out  1       {out_pc, out_inst} presented to decode
//  out_pc          out  64      PC of presented instruction
//  out_inst        out  INST_W  presented instruction
//  busy            out  1       1 in DRAIN or HOLD (fetch not progressing)
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, out_valid=0, out_pc=0, out_inst=0, skid empty.
//   ireq_valid=0 and busy=0 while in reset. Reset mid-transfer abandons the transfer.
//  States:
//   IDLE:  ireq_valid=0; next cycle -> FETCH.
//   FETCH: ireq_valid=1, ireq_addr=pc.
//   DRAIN: ireq_valid=1, addr held; response will be discarded.
//   HOLD:  ireq_valid=0; skid full.
//  Consume rule: slot_free = !out_valid || !stall. Decode takes the slot when out_valid && !stall.
//  Priority in every state: reset > redirect_valid > normal sequencing.
//  FETCH, iresp_ok, no redirect:
//   slot_free   -> out <= {pc, iresp_data}, out_valid=1, pc<=pc+4, stay FETCH.
//                  Back-to-back: 1 instruction/cycle when the bus answers each cycle.
//   !slot_free  -> skid <= {pc, iresp_data}, pc<=pc+4, -> HOLD.
//  FETCH, !iresp_ok: hold addr. out_valid <= out_valid && stall.
//  HOLD, !stall: out <= skid, skid empty, -> FETCH. HOLD, stall: unchanged.
//  Redirect, any state (same cycle): pc<=redirect_pc, out_valid<=0, skid emptied.
//   FETCH && !iresp_ok  -> DRAIN (bus request must not be withdrawn).
//   FETCH && iresp_ok   -> response dropped, -> FETCH at target next cycle.
//   IDLE / HOLD         -> FETCH.
//   DRAIN               -> target overwritten by newest redirect, stay DRAIN
//                          unless iresp_ok (then -> FETCH).
//  DRAIN, iresp_ok, no redirect: data dropped, -> FETCH with ireq_addr=pc (target).
//  pc+4 wraps modulo 2^64. No instruction older than a redirect is presented after it.
//  Latency: ireq_valid rises 1 cycle after reset release. iresp_ok to out_valid is 1 cycle.
// TESTING
//  1 Reset release, bus answers every cycle, stall=0:
//    ireq_addr 8000_0000, _0004, _0008; out_pc follows 1 cycle later; out_valid stays 1.
//  2 Bus answers 3 cycles late:
//    ireq_addr held 8000_0000 for 3 cycles, out_valid=0 meanwhile, then out_pc=8000_0000.
//  3 stall=1 with out full, iresp_ok for 8000_0004:
//    -> HOLD, busy=1, ireq_valid=0. stall=0 -> out_pc=8000_0004, fetch 8000_0008.
//  4 redirect_pc=8000_0100 while request for 8000_0008 pending:
//    DRAIN, addr stays _0008. On its iresp_ok data not presented; next ireq_addr=8000_0100.
//  5 redirect same cycle as iresp_ok, and redirect while in HOLD:
//    out_valid=0 next cycle, skid dropped, next ireq_addr = target.
//  6 reset=0 asserted during DRAIN:
//    next cycle IDLE, out_valid=0, then ireq_addr=8000_0000.
//    pc=FFFF_FFFF_FFFF_FFFC fetch -> next addr 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Fetch-stage sequencer. Owns the fetch PC, drives the
//                instruction-bus request, and hands {pc, inst} to decode
//                through a registered output slot backed by a one-entry skid.
//                Handles redirects, decode back-pressure and the discard of
//                responses to requests made obsolete by a redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          INST_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ireq_valid,
  output logic [63:0]       ireq_addr,
  input  logic              iresp_ok,
  input  logic [INST_W-1:0] iresp_data,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_pc,
  input  logic              stall,
  output logic              out_valid,
  output logic [63:0]       out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              busy
);

  // IDLE  : one cycle after reset, no request
  // FETCH : request at r_ireq_addr (== r_pc), responses are delivered
  // DRAIN : request kept up for an obsolete address, response is discarded
  // HOLD  : output slot and skid both full, fetch paused
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t            r_state;
  logic [63:0]       r_pc;          // next address to fetch (redirect target while draining)
  logic              r_ireq_valid;
  logic [63:0]       r_ireq_addr;   // held separately so DRAIN keeps the old address on the bus
  logic              r_out_valid;
  logic [63:0]       r_out_pc;
  logic [INST_W-1:0] r_out_inst;
  logic [63:0]       r_skid_pc;     // skid occupancy is implied by ST_HOLD
  logic [INST_W-1:0] r_skid_inst;
  logic              r_busy;

  logic              w_slot_free;
  logic              w_keep_out;
  logic [63:0]       w_pc_inc;

  // Output slot can take a new entry when empty or when decode consumes it now
  assign w_slot_free = !r_out_valid || !stall;
  assign w_keep_out  = r_out_valid && stall;
  assign w_pc_inc    = r_pc + 64'd4;   // wraps modulo 2^64

  // Sequencer: state, PC, bus request, output slot and skid, all registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_ireq_valid <= 1'b0;
      r_ireq_addr  <= RESET_PC;
      r_out_valid  <= 1'b0;
      r_out_pc     <= 64'd0;
      r_out_inst   <= '0;
      r_skid_pc    <= 64'd0;
      r_skid_inst  <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state      <= ST_FETCH;
          r_ireq_valid <= 1'b1;
          r_busy       <= 1'b0;
          r_out_valid  <= 1'b0;
          if (redirect_valid) begin
            r_pc        <= redirect_pc;
            r_ireq_addr <= redirect_pc;
          end else begin
            r_ireq_addr <= r_pc;
          end
        end

        ST_FETCH: begin
          if (redirect_valid) begin
            r_pc        <= redirect_pc;
            r_out_valid <= 1'b0;
            if (iresp_ok) begin
              // Completed response belongs to the old stream: drop it
              r_ireq_addr <= redirect_pc;
              r_busy      <= 1'b0;
            end else begin
              // Request already on the bus cannot be withdrawn
              r_state <= ST_DRAIN;
              r_busy  <= 1'b1;
            end
          end else if (iresp_ok) begin
            r_pc        <= w_pc_inc;
            r_ireq_addr <= w_pc_inc;
            if (w_slot_free) begin
              r_out_valid <= 1'b1;
              r_out_pc    <= r_pc;
              r_out_inst  <= iresp_data;
            end else begin
              r_skid_pc    <= r_pc;
              r_skid_inst  <= iresp_data;
              r_state      <= ST_HOLD;
              r_ireq_valid <= 1'b0;
              r_busy       <= 1'b1;
            end
          end else begin
            r_out_valid <= w_keep_out;
          end
        end

        ST_DRAIN: begin
          // Output slot was flushed on entry and nothing is loaded here
          r_out_valid <= 1'b0;
          if (redirect_valid) begin
            r_pc <= redirect_pc;
          end
          if (iresp_ok) begin
            r_state     <= ST_FETCH;
            r_busy      <= 1'b0;
            r_ireq_addr <= redirect_valid ? redirect_pc : r_pc;
          end
        end

        ST_HOLD: begin
          if (redirect_valid) begin
            r_pc         <= redirect_pc;
            r_ireq_addr  <= redirect_pc;
            r_out_valid  <= 1'b0;
            r_state      <= ST_FETCH;
            r_ireq_valid <= 1'b1;
            r_busy       <= 1'b0;
          end else if (!stall) begin
            r_out_valid  <= 1'b1;
            r_out_pc     <= r_skid_pc;
            r_out_inst   <= r_skid_inst;
            r_state      <= ST_FETCH;
            r_ireq_valid <= 1'b1;
            r_busy       <= 1'b0;
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_ireq_valid <= 1'b0;
          r_out_valid  <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign ireq_valid = r_ireq_valid;
  assign ireq_addr  = r_ireq_addr;
  assign out_valid  = r_out_valid;
  assign out_pc     = r_out_pc;
  assign out_inst   = r_out_inst;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Randomized self-checking bench for fetch_ctrl. A queue-based
//                reference model tracks delivered-but-unconsumed instructions
//                (head = output slot, second entry = skid) and the fetch
//                stream position.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam logic [63:0] C_RESET_PC = 64'h8000_0000;
  localparam int          C_INST_W   = 32;
  localparam int          C_CYCLES   = 4000;

  logic                clk = 1'b0;
  logic                reset;
  logic                ireq_valid;
  logic [63:0]         ireq_addr;
  logic                iresp_ok;
  logic [C_INST_W-1:0] iresp_data;
  logic                redirect_valid;
  logic [63:0]         redirect_pc;
  logic                stall;
  logic                out_valid;
  logic [63:0]         out_pc;
  logic [C_INST_W-1:0] out_inst;
  logic                busy;

  fetch_ctrl #(
    .RESET_PC (C_RESET_PC),
    .INST_W   (C_INST_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_ok       (iresp_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]         pc;
    logic [C_INST_W-1:0] inst;
  } ent_t;

  // Reference model state
  ent_t        m_q[$];     // instructions delivered to decode, oldest first
  bit          m_started;  // left the post-reset idle cycle
  bit          m_drain;    // outstanding request's data is unwanted
  bit          m_req;      // bus request expected this cycle
  bit          m_zero;     // output registers still hold their reset value
  logic [63:0] m_pc;       // next address of the live instruction stream
  logic [63:0] m_addr;     // address currently on the bus

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge
  task automatic model_step();
    bit fire;
    ent_t e;
    if (!reset) begin
      m_q.delete();
      m_started = 0;
      m_drain   = 0;
      m_zero    = 1;
      m_pc      = C_RESET_PC;
      m_addr    = C_RESET_PC;
    end else if (!m_started) begin
      m_started = 1;
      if (redirect_valid) m_pc = redirect_pc;
      m_addr = m_pc;
    end else begin
      fire = m_req && iresp_ok;
      if (redirect_valid) begin
        m_q.delete();
        m_pc = redirect_pc;
        if (m_req && !fire) begin
          m_drain = 1;
        end else begin
          m_drain = 0;
          m_addr  = redirect_pc;
        end
      end else begin
        if (m_q.size() > 0 && !stall) void'(m_q.pop_front());
        if (fire) begin
          if (m_drain) begin
            m_drain = 0;
            m_addr  = m_pc;
          end else begin
            e.pc   = m_addr;
            e.inst = iresp_data;
            m_q.push_back(e);
            m_zero = 0;
            m_pc   = m_addr + 64'd4;
            m_addr = m_pc;
          end
        end
      end
    end
    m_req = m_started && (m_drain || m_q.size() < 2);
  endtask

  task automatic check_outputs();
    check("ireq_valid", {63'd0, ireq_valid}, {63'd0, m_req});
    if (m_req) check("ireq_addr", ireq_addr, m_addr);
    check("out_valid", {63'd0, out_valid}, {63'd0, (m_q.size() > 0)});
    if (m_q.size() > 0) begin
      check("out_pc", out_pc, m_q[0].pc);
      check("out_inst", {32'd0, out_inst}, {32'd0, m_q[0].inst});
    end else if (m_zero) begin
      check("out_pc_reset", out_pc, 64'd0);
      check("out_inst_reset", {32'd0, out_inst}, 64'd0);
    end
    check("busy", {63'd0, busy}, {63'd0, (m_started && (m_drain || m_q.size() == 2))});
  endtask

  function automatic logic [63:0] pick_target();
    logic [63:0] t;
    case ($urandom_range(0, 3))
      0:       t = 64'hFFFF_FFFF_FFFF_FFF8;
      1:       t = C_RESET_PC + {54'd0, 8'($urandom_range(0, 255)), 2'b00};
      default: t = {$urandom, $urandom} & ~64'd3;
    endcase
    return t;
  endfunction

  // Inputs for the next edge; phase selects directed or random behaviour
  task automatic drive(input int cyc);
    int stall_pct;
    int ok_pct;
    iresp_data = $urandom;
    if (cyc < 3) begin
      reset          = 1'b0;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      iresp_ok       = 1'b0;
    end else if (cyc < 20) begin
      // Free-running stream from the reset PC
      reset          = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      iresp_ok       = ireq_valid;
    end else if (cyc == 20) begin
      // Jump to the top of the address space to exercise wrap
      reset          = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      iresp_ok       = ireq_valid;
    end else if (cyc < 30) begin
      reset          = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      iresp_ok       = ireq_valid;
    end else begin
      stall_pct = ((cyc / 400) % 2 == 1) ? 65 : 20;
      ok_pct    = ((cyc / 300) % 2 == 1) ? 30 : 80;
      reset          = ($urandom_range(0, 199) < 2) ? 1'b0 : 1'b1;
      stall          = ($urandom_range(0, 99) < stall_pct);
      redirect_valid = ($urandom_range(0, 99) < 7);
      redirect_pc    = pick_target();
      iresp_ok       = ireq_valid && ($urandom_range(0, 99) < ok_pct);
    end
  endtask

  initial begin
    reset          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    iresp_ok       = 1'b0;
    iresp_data     = '0;
    m_req          = 0;
    m_started      = 0;
    m_drain        = 0;
    m_zero         = 1;
    m_pc           = C_RESET_PC;
    m_addr         = C_RESET_PC;
    for (int cyc = 0; cyc < C_CYCLES; cyc++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
      drive(cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
